// File: rtl/floo_pkg.sv
// Shared FlooNoC types: routing algorithm selector, XY directions, default flit and ID-table rule.
package floo_pkg;

  typedef enum logic [1:0] {IdIsPort, IdTable, SourceRouting, XYRouting} route_algo_e;

  typedef enum logic [2:0] {
    Eject = 3'd0,
    North = 3'd1,
    East  = 3'd2,
    South = 3'd3,
    West  = 3'd4
  } route_direction_e;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } xy_id_t;

  typedef struct packed {
    xy_id_t dst_id;
    logic   last;
  } floo_hdr_t;

  typedef struct packed {
    floo_hdr_t   hdr;
    logic [15:0] payload;
  } floo_flit_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
  } id_rule_t;

  // A single-VC port still carries a 1-bit VC field.
  function automatic int unsigned vc_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_route_compute.sv
// Pure combinational route lookup: one-hot output port plus the rewritten dst_id.
module floo_route_compute
  import floo_pkg::*;
#(
  parameter int unsigned NumRoutes     = 5,
  parameter route_algo_e RouteAlgo     = XYRouting,
  parameter int unsigned IdWidth       = 6,
  parameter int unsigned RouteSelWidth = 3,
  parameter int unsigned NumAddrRules  = 1,
  parameter type         addr_rule_t   = id_rule_t
) (
  input  logic [IdWidth-1:0]                 dst_id_i,
  input  logic [IdWidth-1:0]                 xy_id_i,
  input  addr_rule_t [NumAddrRules-1:0]      id_route_map_i,
  output logic [NumRoutes-1:0]               route_o,
  output logic [IdWidth-1:0]                 dst_id_o
);

  localparam int unsigned PortW = (NumRoutes > 1) ? $clog2(NumRoutes) : 1;
  localparam int unsigned YW    = IdWidth / 2;

  if (NumRoutes < 2) begin : g_bad_routes
    $fatal(1, "floo_route_compute: NumRoutes must be at least 2");
  end

  case (RouteAlgo)
    XYRouting: begin : g_xy
      if (NumRoutes < 5 || IdWidth < 2) begin : g_bad_xy
        $fatal(1, "floo_route_compute: XYRouting needs 5 routes and a 2-D id");
      end
      logic [IdWidth-YW-1:0] dst_x, own_x;
      logic [YW-1:0]         dst_y, own_y;
      logic                  unused_map;
      assign {dst_x, dst_y} = dst_id_i;
      assign {own_x, own_y} = xy_id_i;
      assign unused_map     = ^id_route_map_i;
      // Resolve X first, then Y (dimension-ordered, deadlock-free on a mesh).
      always_comb begin
        route_o = '0;
        if (dst_id_i == xy_id_i)  route_o[Eject] = 1'b1;
        else if (dst_x == own_x)  route_o[(dst_y < own_y) ? South : North] = 1'b1;
        else                      route_o[(dst_x < own_x) ? West : East] = 1'b1;
      end
      assign dst_id_o = dst_id_i;
    end
    SourceRouting: begin : g_src
      logic unused_src;
      assign unused_src = ^{xy_id_i, id_route_map_i};
      // Each hop consumes the low field and hands the remainder downstream.
      assign route_o  = NumRoutes'(1) << dst_id_i[RouteSelWidth-1:0];
      assign dst_id_o = dst_id_i >> RouteSelWidth;
    end
    IdIsPort: begin : g_port
      logic unused_port;
      assign unused_port = ^{xy_id_i, id_route_map_i};
      assign route_o     = NumRoutes'(1) << dst_id_i;
      assign dst_id_o    = dst_id_i;
    end
    IdTable: begin : g_table
      logic [PortW-1:0] port;
      logic             unused_tbl;
      assign unused_tbl = ^{xy_id_i, id_route_map_i};
      // Unmatched ids fall back to port 0; later rules override earlier ones.
      always_comb begin
        port = '0;
        for (int i = 0; i < NumAddrRules; i++) begin
          if (dst_id_i >= IdWidth'(id_route_map_i[i].start_addr) &&
              dst_id_i <  IdWidth'(id_route_map_i[i].end_addr))
            port = PortW'(id_route_map_i[i].idx);
        end
      end
      assign route_o  = NumRoutes'(1) << port;
      assign dst_id_o = dst_id_i;
    end
    default: begin : g_bad_algo
      $fatal(1, "floo_route_compute: unknown RouteAlgo");
    end
  endcase

endmodule

// File: rtl/floo_vc_route_select.sv
// Per-input-port route selector: per-VC wormhole lock, mismatch counter, optional output cut.
module floo_vc_route_select
  import floo_pkg::*;
#(
  parameter int unsigned NumRoutes       = 5,
  parameter int unsigned NumVirtChannels = 1,
  parameter type         flit_t          = floo_flit_t,
  parameter route_algo_e RouteAlgo       = XYRouting,
  parameter bit          LockRouting     = 1'b1,
  parameter bit          CutPath         = 1'b0,
  parameter int unsigned IdWidth         = 6,
  parameter type         id_t            = xy_id_t,
  parameter int unsigned NumAddrRules    = 1,
  parameter type         addr_rule_t     = id_rule_t,
  parameter int unsigned RouteSelWidth   = (NumRoutes > 1) ? $clog2(NumRoutes) : 1,
  parameter int unsigned ErrCntWidth     = 8,
  localparam int unsigned VcW            = vc_id_width(NumVirtChannels)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          test_enable_i,
  input  id_t                           xy_id_i,
  input  addr_rule_t [NumAddrRules-1:0] id_route_map_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  flit_t                         channel_i,
  input  logic [VcW-1:0]                vc_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output flit_t                         channel_o,
  output logic [VcW-1:0]                vc_o,
  output logic [NumRoutes-1:0]          route_sel_o,
  output logic [NumVirtChannels-1:0]    locked_o,
  output logic                          err_o,
  output logic [ErrCntWidth-1:0]        err_cnt_o,
  input  logic                          err_clr_i
);

  typedef enum logic {Unlocked, Locked} lock_state_e;

  lock_state_e          state_q [NumVirtChannels];
  lock_state_e          state_d [NumVirtChannels];
  logic [NumRoutes-1:0] route_q [NumVirtChannels];
  logic [NumRoutes-1:0] route_d [NumVirtChannels];
  logic [NumRoutes-1:0] route_calc, route_sel;
  logic [IdWidth-1:0]   dst_new;
  logic                 accept, vc_locked, mismatch;
  logic                 unused_dft;
  flit_t                chan_fwd;

  assign unused_dft = test_enable_i;

  floo_route_compute #(
    .NumRoutes    (NumRoutes),
    .RouteAlgo    (RouteAlgo),
    .IdWidth      (IdWidth),
    .RouteSelWidth(RouteSelWidth),
    .NumAddrRules (NumAddrRules),
    .addr_rule_t  (addr_rule_t)
  ) i_compute (
    .dst_id_i      (channel_i.hdr.dst_id),
    .xy_id_i       (xy_id_i),
    .id_route_map_i(id_route_map_i),
    .route_o       (route_calc),
    .dst_id_o      (dst_new)
  );

  assign accept    = valid_i & ready_o;
  assign vc_locked = LockRouting && (state_q[vc_i] == Locked);
  assign route_sel = vc_locked ? route_q[vc_i] : route_calc;
  assign mismatch  = accept & vc_locked & (route_calc != route_q[vc_i]);

  // Only the addressed VC moves; a head that is also last never locks.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (LockRouting && accept) begin
      case (state_q[vc_i])
        Unlocked: if (!channel_i.hdr.last) begin
          state_d[vc_i] = Locked;
          route_d[vc_i] = route_calc;
        end
        Locked: if (channel_i.hdr.last) state_d[vc_i] = Unlocked;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumVirtChannels; i++) begin
        state_q[i] <= Unlocked;
        route_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_locked
    assign locked_o[v] = (state_q[v] == Locked);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (mismatch) begin
      err_o <= 1'b1;
      if (~&err_cnt_o) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  always_comb begin
    chan_fwd            = channel_i;
    chan_fwd.hdr.dst_id = id_t'(dst_new);
  end

  if (CutPath) begin : g_cut
    logic                 full_q;
    flit_t                chan_q;
    logic [VcW-1:0]       vc_q;
    logic [NumRoutes-1:0] sel_q;

    // Refill in the same cycle the held flit drains, so throughput stays at one per cycle.
    assign ready_o = ~full_q | ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        full_q <= 1'b0;
        chan_q <= '0;
        vc_q   <= '0;
        sel_q  <= '0;
      end else if (accept) begin
        full_q <= 1'b1;
        chan_q <= chan_fwd;
        vc_q   <= vc_i;
        sel_q  <= route_sel;
      end else if (ready_i) begin
        full_q <= 1'b0;
      end
    end

    assign valid_o     = full_q;
    assign channel_o   = chan_q;
    assign vc_o        = vc_q;
    assign route_sel_o = sel_q;
  end else begin : g_comb
    assign ready_o     = ready_i;
    assign valid_o     = valid_i;
    assign channel_o   = chan_fwd;
    assign vc_o        = vc_i;
    assign route_sel_o = route_sel;
  end

endmodule

// File: tb/tb_floo_vc_route_select.sv
// Directed + randomized bench: XY with 2 VCs, SourceRouting, and an XY instance with the output cut.
module tb_floo_vc_route_select;
  import floo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam xy_id_t OWN = '{x: 3'd2, y: 3'd2};
  id_rule_t [0:0] map = '0;

  typedef logic [4:0] sr_id_t;
  typedef struct packed { sr_id_t dst_id; logic last; } sr_hdr_t;
  typedef struct packed { sr_hdr_t hdr; logic [7:0] payload; } sr_flit_t;
  typedef struct { floo_flit_t chan; logic [4:0] sel; } exp_t;

  // ---------------- XY, 2 VCs, combinational ----------------
  logic       xy_valid = 1'b0, xy_ri = 1'b1, xy_clr = 1'b0, xy_vc = 1'b0;
  logic       xy_ready, xy_vo, xy_err, xy_vco;
  floo_flit_t xy_chan = '0, xy_cho;
  logic [4:0] xy_sel;
  logic [1:0] xy_locked, xy_cnt;

  floo_vc_route_select #(
    .NumRoutes(5), .NumVirtChannels(2), .RouteAlgo(XYRouting), .LockRouting(1'b1),
    .CutPath(1'b0), .IdWidth(6), .ErrCntWidth(2)
  ) u_xy (
    .clk_i(clk), .rst_i(rst), .test_enable_i(1'b0), .xy_id_i(OWN), .id_route_map_i(map),
    .valid_i(xy_valid), .ready_o(xy_ready), .channel_i(xy_chan), .vc_i(xy_vc),
    .valid_o(xy_vo), .ready_i(xy_ri), .channel_o(xy_cho), .vc_o(xy_vco),
    .route_sel_o(xy_sel), .locked_o(xy_locked), .err_o(xy_err), .err_cnt_o(xy_cnt),
    .err_clr_i(xy_clr)
  );

  // ---------------- SourceRouting, no lock ----------------
  logic       sr_valid = 1'b0, sr_ri = 1'b1;
  logic       sr_ready, sr_vo, sr_err, sr_vco, sr_locked;
  sr_flit_t   sr_chan = '0, sr_cho;
  logic [4:0] sr_sel;
  logic [7:0] sr_cnt;

  floo_vc_route_select #(
    .NumRoutes(5), .NumVirtChannels(1), .flit_t(sr_flit_t), .RouteAlgo(SourceRouting),
    .LockRouting(1'b0), .CutPath(1'b0), .IdWidth(5), .id_t(sr_id_t), .RouteSelWidth(3)
  ) u_sr (
    .clk_i(clk), .rst_i(rst), .test_enable_i(1'b0), .xy_id_i(5'd0), .id_route_map_i(map),
    .valid_i(sr_valid), .ready_o(sr_ready), .channel_i(sr_chan), .vc_i(1'b0),
    .valid_o(sr_vo), .ready_i(sr_ri), .channel_o(sr_cho), .vc_o(sr_vco),
    .route_sel_o(sr_sel), .locked_o(sr_locked), .err_o(sr_err), .err_cnt_o(sr_cnt),
    .err_clr_i(1'b0)
  );

  // ---------------- XY, 1 VC, registered output ----------------
  logic       ct_valid = 1'b0, ct_ri = 1'b1;
  logic       ct_ready, ct_vo, ct_err, ct_vco, ct_locked;
  floo_flit_t ct_chan = '0, ct_cho;
  logic [4:0] ct_sel;
  logic [7:0] ct_cnt;

  floo_vc_route_select #(
    .NumRoutes(5), .NumVirtChannels(1), .RouteAlgo(XYRouting), .LockRouting(1'b1),
    .CutPath(1'b1), .IdWidth(6)
  ) u_cut (
    .clk_i(clk), .rst_i(rst), .test_enable_i(1'b0), .xy_id_i(OWN), .id_route_map_i(map),
    .valid_i(ct_valid), .ready_o(ct_ready), .channel_i(ct_chan), .vc_i(1'b0),
    .valid_o(ct_vo), .ready_i(ct_ri), .channel_o(ct_cho), .vc_o(ct_vco),
    .route_sel_o(ct_sel), .locked_o(ct_locked), .err_o(ct_err), .err_cnt_o(ct_cnt),
    .err_clr_i(1'b0)
  );

  // Reference model state for u_xy: which VCs are mid-packet and the port their head took.
  bit lk [2];
  int rt [2];
  int ecnt;
  bit eflg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Dimension-ordered routing from node (2,2), as port numbers of route_direction_e.
  function automatic int xy_port(input int dx, input int dy);
    if (dx == 2 && dy == 2) return int'(Eject);
    if (dx == 2) return (dy < 2) ? int'(South) : int'(North);
    return (dx < 2) ? int'(West) : int'(East);
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, "/lock"}, xy_locked, 2'b00);
    chk({tag, "/err"}, {xy_err, xy_cnt}, 3'b000);
    chk({tag, "/cutv"}, ct_vo, 1'b0);
    lk[0] = 1'b0; lk[1] = 1'b0; ecnt = 0; eflg = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // exp_port >= 0 additionally pins the route to a hand-derived value.
  task automatic xy_send(input int dx, input int dy, input int vc, input bit last,
                         input bit clr, input int exp_port, input string tag);
    int p, want;
    bit mm;
    @(negedge clk);
    xy_chan.hdr.dst_id.x = 3'(dx);
    xy_chan.hdr.dst_id.y = 3'(dy);
    xy_chan.hdr.last     = last;
    xy_chan.payload      = 16'($urandom);
    xy_vc    = 1'(vc);
    xy_valid = 1'b1;
    xy_clr   = clr;
    #1;
    p    = xy_port(dx, dy);
    want = lk[vc] ? rt[vc] : p;
    if (exp_port >= 0) chk({tag, "/spec"}, xy_sel, 5'(1) << exp_port);
    chk({tag, "/sel"}, xy_sel, 5'(1) << want);
    chk({tag, "/hs"}, {xy_vo, xy_ready, xy_vco}, {1'b1, 1'b1, 1'(vc)});
    chk({tag, "/chan"}, xy_cho, xy_chan);
    mm = lk[vc] && (p != rt[vc]);
    if (clr) begin ecnt = 0; eflg = 1'b0; end
    else if (mm) begin eflg = 1'b1; if (ecnt < 3) ecnt++; end
    if (!lk[vc]) begin
      if (!last) begin lk[vc] = 1'b1; rt[vc] = p; end
    end else if (last) lk[vc] = 1'b0;
    @(posedge clk);
    #1;
    xy_valid = 1'b0;
    xy_clr   = 1'b0;
    chk({tag, "/lock"}, xy_locked, {lk[1], lk[0]});
    chk({tag, "/err"}, {xy_err, xy_cnt}, {eflg, 2'(ecnt)});
  endtask

  initial begin
    exp_t       q[$];
    exp_t       e;
    floo_flit_t cur;
    logic [4:0] s;
    logic [4:0] d;
    int         seq, c_err, c_rt, p, want;
    bit         c_lk, acc, pop;

    lk[0] = 1'b0; lk[1] = 1'b0; rt[0] = 0; rt[1] = 0; ecnt = 0; eflg = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("init");

    // SourceRouting: low 3 bits pick the port, the rest travels on.
    @(negedge clk);
    sr_chan.hdr.dst_id = 5'b10011;
    sr_chan.hdr.last   = 1'b0;
    sr_chan.payload    = 8'hA5;
    sr_valid = 1'b1;
    #1;
    chk("sr/sel", sr_sel, 5'b01000);
    chk("sr/dst", sr_cho.hdr.dst_id, 5'b00010);
    chk("sr/pay", {sr_cho.payload, sr_vo, sr_ready, sr_vco}, {8'hA5, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d = 5'($urandom);
      sr_chan.hdr.dst_id = d;
      sr_chan.hdr.last   = 1'($urandom);
      #1;
      s = '0;
      if (int'(d % 8) < 5) s[d % 8] = 1'b1;
      chk("sr/rsel", sr_sel, s);
      chk("sr/rdst", sr_cho.hdr.dst_id, d / 8);
      @(posedge clk);
      #1;
      chk("sr/nolock", {sr_locked, sr_err, sr_cnt}, 10'd0);
    end
    sr_valid = 1'b0;

    // Single-flit packets from (2,2).
    xy_send(2, 2, 0, 1'b1, 1'b0, int'(Eject), "s_eject");
    xy_send(2, 0, 0, 1'b1, 1'b0, int'(South), "s_south");
    xy_send(2, 3, 0, 1'b1, 1'b0, int'(North), "s_north");
    xy_send(0, 2, 0, 1'b1, 1'b0, int'(West),  "s_west");
    xy_send(3, 2, 0, 1'b1, 1'b0, int'(East),  "s_east");

    // 4-flit packet whose body ids are corrupted: stays East, three mismatches.
    xy_send(3, 2, 0, 1'b0, 1'b0, int'(East), "p_head");
    xy_send(0, 2, 0, 1'b0, 1'b0, int'(East), "p_b1");
    xy_send(0, 2, 0, 1'b0, 1'b0, int'(East), "p_b2");
    xy_send(0, 2, 0, 1'b1, 1'b0, int'(East), "p_last");
    chk("p_cnt3", xy_cnt, 2'd3);
    // Counter already saturated, then clear collides with another mismatch.
    xy_send(3, 2, 0, 1'b0, 1'b0, int'(East), "sat_head");
    xy_send(0, 2, 0, 1'b1, 1'b0, int'(East), "sat_last");
    xy_send(3, 2, 0, 1'b0, 1'b0, int'(East), "clr_head");
    xy_send(0, 2, 0, 1'b1, 1'b1, int'(East), "clr_last");

    // Interleaved VCs.
    xy_send(3, 2, 0, 1'b0, 1'b0, int'(East), "il_v0h");
    chk("il_lock1", xy_locked, 2'b01);
    xy_send(0, 2, 1, 1'b1, 1'b0, int'(West), "il_v1");
    chk("il_lock2", xy_locked, 2'b01);
    xy_send(3, 2, 0, 1'b1, 1'b0, int'(East), "il_v0l");
    chk("il_lock3", xy_locked, 2'b00);

    // Reset mid-packet drops the lock and the error state.
    xy_send(3, 2, 0, 1'b0, 1'b0, int'(East), "rm_head");
    xy_send(0, 2, 0, 1'b0, 1'b0, int'(East), "rm_body");
    do_reset("rm_rst");
    xy_send(0, 2, 0, 1'b1, 1'b0, int'(West), "rm_next");

    for (int i = 0; i < 200; i++)
      xy_send($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 1),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), -1, "rnd");

    // Registered path: scoreboard of at most one in-flight flit.
    seq = 0; c_err = 0; c_rt = 0; c_lk = 1'b0;
    cur = '0;
    cur.hdr.dst_id = '{x: 3'd3, y: 3'd2};
    for (int c = 0; c < 305; c++) begin
      @(negedge clk);
      if (c < 10) begin
        ct_valid = 1'b1;
        ct_ri    = !(c >= 3 && c < 6);
      end else if (c < 300) begin
        ct_valid = ($urandom_range(0, 3) != 0);
        ct_ri    = ($urandom_range(0, 3) != 0);
      end else begin
        ct_valid = 1'b0;
        ct_ri    = 1'b1;
      end
      ct_chan = cur;
      #1;
      chk("cut/vo", ct_vo, q.size() != 0);
      if (q.size() != 0) chk("cut/out", {ct_cho, ct_sel, ct_vco}, {q[0].chan, q[0].sel, 1'b0});
      chk("cut/rdy", ct_ready, (q.size() == 0) || ct_ri);
      acc = ct_valid && ((q.size() == 0) || ct_ri);
      pop = (q.size() != 0) && ct_ri;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) begin
        p    = xy_port(int'(cur.hdr.dst_id.x), int'(cur.hdr.dst_id.y));
        want = c_lk ? c_rt : p;
        if (c_lk && p != c_rt) c_err++;
        if (!c_lk) begin
          if (!cur.hdr.last) begin c_lk = 1'b1; c_rt = p; end
        end else if (cur.hdr.last) c_lk = 1'b0;
        s      = 5'(1) << want;
        e.chan = cur;
        e.sel  = s;
        q.push_back(e);
        seq++;
        cur.hdr.dst_id.x = 3'($urandom_range(0, 4));
        cur.hdr.dst_id.y = 3'($urandom_range(0, 4));
        cur.hdr.last     = (seq >= 6) && ($urandom_range(0, 2) == 0);
        cur.payload      = 16'(seq);
      end
    end
    #1;
    chk("cut/lock", ct_locked, c_lk);
    chk("cut/err", {ct_err, ct_cnt}, {(c_err != 0), 8'(c_err)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
